// File: rtl/mau_pkg.sv
// Shared encodings for mem_access_unit: request sizes, memory write codes and FSM states.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_W = 2'b01;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_W    = 2'd1;
  localparam logic [1:0] MW_B    = 2'd2;
  localparam logic [1:0] MW_D    = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Reserved size 2'b10 falls into the dword code.
  function automatic logic [1:0] store_code(input logic [1:0] size);
    case (size)
      SZ_B:    return MW_B;
      SZ_W:    return MW_W;
      default: return MW_D;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian byte/word extraction from the memory read port, with sign or zero extension.
// Purely combinational; no state and no backpressure.
module load_align
  import mau_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] readdata,
  input  logic [1:0]   addr,
  input  logic [1:0]   size,
  input  logic         zero_ext,
  output logic [N-1:0] data
);

  logic [31:0] word;
  logic [7:0]  byte_sel;

  always_comb begin
    word = readdata[31:0];
    // Byte 0 of a word is its most significant lane.
    case (addr)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    case (size)
      SZ_B:    data = zero_ext ? {{(N-8){1'b0}}, byte_sel} : {{(N-8){byte_sel[7]}}, byte_sel};
      SZ_W:    data = zero_ext ? {{(N-32){1'b0}}, word} : {{(N-32){word[31]}}, word};
      default: data = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit driving the data memory; misalign trap under MAU_MISALIGN_CHECK_EN.
// Response 2 cycles after accept (1 on misalign); req_ready low until the response is taken, rsp held while rsp_ready low.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         mem_dword,
  output logic [1:0]   mem_memwrite,
  output logic [N-1:0] mem_dataadr,
  output logic [N-1:0] mem_writedata,
  input  logic [N-1:0] mem_readdata
);

  state_t      state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        zero_ext_q;
  logic [1:0]  memwrite_q;
  logic        misalign;
  logic [N-1:0] load_data;

`ifdef MAU_MISALIGN_CHECK_EN
  assign misalign = ((req_size == SZ_W) && (req_addr[1:0] != 2'b00)) ||
                    (req_size[1] && (req_addr[2:0] != 3'b000));
`else
  assign misalign = 1'b0;
`endif

  load_align #(.N(N)) u_load_align (
    .readdata (mem_readdata),
    .addr     (mem_dataadr[1:0]),
    .size     (size_q),
    .zero_ext (zero_ext_q),
    .data     (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_dword     <= 1'b0;
      memwrite_q    <= MW_NONE;
      mem_dataadr   <= '0;
      mem_writedata <= '0;
      write_q       <= 1'b0;
      size_q        <= SZ_B;
      zero_ext_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready  <= 1'b0;
          write_q    <= req_write;
          size_q     <= req_size;
          zero_ext_q <= req_unsigned;
          if (misalign) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state         <= ACCESS;
            mem_dword     <= req_size[1];
            memwrite_q    <= req_write ? store_code(req_size) : MW_NONE;
            mem_dataadr   <= req_addr;
            mem_writedata <= req_write ? req_wdata : '0;
          end
        end
        ACCESS: begin
          state         <= RESP;
          rsp_valid     <= 1'b1;
          rsp_err       <= 1'b0;
          rsp_rdata     <= write_q ? '0 : load_data;
          mem_dword     <= 1'b0;
          memwrite_q    <= MW_NONE;
          mem_dataadr   <= '0;
          mem_writedata <= '0;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset landing in ACCESS must not let the pending store commit.
  assign mem_memwrite = reset ? MW_NONE : memwrite_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a byte-array reference memory.
module tb_mem_access_unit;

`ifdef MAU_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic        mem_dword;
  logic [1:0]  mem_memwrite;
  logic [63:0] mem_dataadr, mem_writedata, mem_readdata;

  mem_access_unit #(.N(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_dword(mem_dword), .mem_memwrite(mem_memwrite), .mem_dataadr(mem_dataadr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference memory: plain byte array, byte address == index, big-endian multi-byte values.
  logic [7:0] ref_mem [0:255];

  function automatic logic [63:0] ref_get(input int base, input int n);
    logic [63:0] v = '0;
    for (int j = 0; j < n; j++) v = (v << 8) | 64'(ref_mem[base + j]);
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input int a, input logic [1:0] sz, input bit uns);
    logic [7:0]  b;
    logic [31:0] w;
    case (sz)
      2'b00: begin
        b = ref_mem[a];
        return uns ? {56'b0, b} : {{56{b[7]}}, b};
      end
      2'b01: begin
        w = ref_get(a - (a % 4), 4)[31:0];
        return uns ? {32'b0, w} : {{32{w[31]}}, w};
      end
      default: return ref_get(a - (a % 8), 8);
    endcase
  endfunction

  task automatic ref_store(input int a, input logic [1:0] sz, input logic [63:0] wd);
    int n;
    int base;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 4 : 8;
    base = a - (a % n);
    for (int j = 0; j < n; j++) ref_mem[base + j] = wd[8*(n-1-j) +: 8];
  endtask

  // Memory the DUT talks to: 32 dwords, combinational read, write on the clock edge.
  logic [63:0] tbmem [0:31];
  logic [63:0] rd_d;
  bit mem_loaded = 0;

  always_comb begin
    rd_d = tbmem[mem_dataadr[7:3]];
    if (mem_dword) mem_readdata = rd_d;
    else           mem_readdata = {32'b0, mem_dataadr[2] ? rd_d[31:0] : rd_d[63:32]};
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 8; j++) tbmem[i][63-8*j -: 8] = ref_mem[8*i + j];
      mem_loaded = 1;
    end else begin
      case (mem_memwrite)
        2'd1: if (mem_dataadr[2]) tbmem[mem_dataadr[7:3]][31:0] = mem_writedata[31:0];
              else                tbmem[mem_dataadr[7:3]][63:32] = mem_writedata[31:0];
        2'd2: tbmem[mem_dataadr[7:3]][63-8*mem_dataadr[2:0] -: 8] = mem_writedata[7:0];
        2'd3: tbmem[mem_dataadr[7:3]] = mem_writedata;
        default: ;
      endcase
    end
  end

  typedef struct { logic [63:0] rdata; bit err; int acc; } exp_t;
  typedef struct { logic [1:0] code; bit dw; logic [63:0] adr; logic [63:0] wdata; } acc_t;
  exp_t exp_q[$];
  acc_t acc_q[$];

  // Response backpressure: random, or forced low for hold_total RESP cycles.
  int hold_total = 0;
  int hold_used = 0;
  initial rsp_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (hold_used < hold_total) begin
      rsp_ready = 1'b0;
      if (rsp_valid) hold_used++;
    end else begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: memory port, handshake exclusivity, response content/latency/stability.
  bit          in_rsp = 0;
  logic [63:0] h_data;
  logic        h_err;
  exp_t        e_m;
  acc_t        a_m;

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("ready_and_valid", {63'b0, rsp_valid & req_ready}, 64'd0);
      if (req_ready || rsp_valid) begin
        chk("mem_idle", {63'b0, (|mem_dataadr) | (|mem_writedata) | mem_dword | (|mem_memwrite)}, 64'd0);
      end else begin
        chk("access_expected", {63'b0, acc_q.size() != 0}, 64'd1);
        if (acc_q.size() != 0) begin
          a_m = acc_q.pop_front();
          chk("mem_memwrite", {62'b0, mem_memwrite}, {62'b0, a_m.code});
          chk("mem_dword", {63'b0, mem_dword}, {63'b0, a_m.dw});
          chk("mem_dataadr", mem_dataadr, a_m.adr);
          if (a_m.code != 2'd0) chk("mem_writedata", mem_writedata, a_m.wdata);
        end
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1;
          h_data = rsp_rdata;
          h_err  = rsp_err;
          chk("rsp_expected", {63'b0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            e_m = exp_q[0];
            chk("latency", 64'(cyc - e_m.acc), e_m.err ? 64'd0 : 64'd1);
            chk("rsp_rdata", rsp_rdata, e_m.rdata);
            chk("rsp_err", {63'b0, rsp_err}, {63'b0, e_m.err});
          end
        end else begin
          chk("hold_rdata", rsp_rdata, h_data);
          chk("hold_err", {63'b0, rsp_err}, {63'b0, h_err});
        end
        if (rsp_ready) begin
          in_rsp = 0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Returns at the start of the ACCESS cycle of the accepted request.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns, input logic [63:0] a,
                       input logic [63:0] wd, input bit drop, input int hold);
    int    w = 0;
    int    ai;
    bit    err;
    exp_t  e;
    acc_t  x;
    @(posedge clk); #1;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", {63'b0, req_ready}, 64'd1);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    hold_total = hold_total + hold;
    ai  = int'(a[7:0]);
    err = CHK_EN && (((sz == 2'b01) && (a[1:0] != 2'b00)) || (sz[1] && (a[2:0] != 3'b000)));
    if (!drop) begin
      e.acc = cyc + 1; e.err = err; e.rdata = '0;
      if (!err) begin
        x.code  = !wr ? 2'd0 : (sz == 2'b00) ? 2'd2 : (sz == 2'b01) ? 2'd1 : 2'd3;
        x.dw    = sz[1];
        x.adr   = a;
        x.wdata = wd;
        acc_q.push_back(x);
        if (wr) ref_store(ai, sz, wd);
        else    e.rdata = ref_load(ai, sz, uns);
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
  endtask

  initial begin
    int w;
    logic [63:0] pre;
    pre = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int j = 0; j < 8; j++) ref_mem[16 + j] = pre[63-8*j -: 8];

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {63'b0, req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_rsp_err", {63'b0, rsp_err}, 64'd0);
    chk("reset_mem", {63'b0, (|mem_dataadr) | (|mem_writedata) | mem_dword | (|mem_memwrite)}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    started = 1;

    issue(0, 2'b00, 0, 64'h14, 64'h0, 0, 0);                    // LB 0x14
    issue(0, 2'b00, 1, 64'h14, 64'h0, 0, 0);                    // LBU 0x14
    issue(0, 2'b01, 0, 64'h10, 64'h0, 0, 0);                    // LW 0x10
    issue(0, 2'b01, 0, 64'h14, 64'h0, 0, 0);                    // LW 0x14
    issue(0, 2'b01, 1, 64'h14, 64'h0, 0, 0);                    // LWU 0x14
    issue(1, 2'b00, 0, 64'h13, 64'hAA, 0, 0);                   // SB 0x13
    issue(0, 2'b11, 0, 64'h10, 64'h0, 0, 0);                    // LD 0x10
    issue(1, 2'b11, 0, 64'h18, 64'h1122_3344_5566_7788, 0, 3);  // SD 0x18, response held
    issue(0, 2'b01, 0, 64'h12, 64'h0, 0, 0);                    // LW 0x12
    issue(1, 2'b11, 0, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 1, 0);  // SD 0x18, killed by reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_access_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_access_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_access_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_access_mem", {63'b0, (|mem_dataadr) | (|mem_writedata) | mem_dword | (|mem_memwrite)}, 64'd0);
    issue(0, 2'b11, 0, 64'h18, 64'h0, 0, 0);                    // LD 0x18 sees the older value

    for (int i = 0; i < 200; i++) begin
      issue($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 1'($urandom),
            64'($urandom_range(0, 255)), {$urandom, $urandom}, 0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    w = 0;
    while ((exp_q.size() != 0 || !req_ready) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    @(negedge clk);
    chk("drain_rsp", 64'(exp_q.size()), 64'd0);
    chk("drain_access", 64'(acc_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store unit for the 64-bit MIPS core. It accepts one load or store request at a time from the pipeline over a valid/ready handshake and drives the data-memory port (`dword`, `memwrite`, `dataadr`, `writedata`, `readdata`). For loads it extracts the big-endian byte or word and sign- or zero-extends it. It returns a response over a second valid/ready handshake. It sits between the execute/memory stage and the data memory.

## Interface
- `N`, default 64: data and address width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 = byte, 01 = word, 11 = dword, 10 = reserved (treated as dword).
- `req_unsigned`  in  1: zero-extend the load result (LBU/LWU); ignored for stores and dword.
- `req_addr`  in  N: byte address.
- `req_wdata`  in  N: store data, right-aligned (byte in [7:0], word in [31:0]).
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_rdata`  out  N: load result; 0 for stores.
- `rsp_err`  out  1: misaligned access (see Configuration).
- `mem_dword`  out  1: to memory `dword`.
- `mem_memwrite`  out  2: to memory `memwrite`; 0 = none, 1 = word, 2 = byte, 3 = dword.
- `mem_dataadr`  out  N: to memory `dataadr`.
- `mem_writedata`  out  N: to memory `writedata`.
- `mem_readdata`  in  N: from memory, combinational from `mem_dataadr`. Non-dword reads return {32'b0, selected word}.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch the request and go to ACCESS (or to RESP with error; see Configuration).
  - ACCESS: lasts exactly one cycle. Drives the memory port from the latched request. On the clock edge it captures the load result, then goes to RESP.
  - RESP: `rsp_valid`=1, and `rsp_rdata`/`rsp_err` are held stable. On `rsp_ready`, go to IDLE.
- Memory port outputs are driven only in ACCESS. In all other states every `mem_*` output is 0.
- Memory drive in ACCESS:
  - `mem_dword` = 1 for dword, else 0.
  - `mem_memwrite` = 3, 1 or 2 for a dword, word or byte store; 0 for loads.
- Load extraction uses big-endian byte order:
  - Word: take `mem_readdata[31:0]`.
  - Byte: select from `mem_readdata[31:0]` by `addr[1:0]`; 00 → [31:24], 11 → [7:0].
  - Extend to N bits, signed unless `req_unsigned`.
- Store: `mem_writedata` = `req_wdata` unmodified. Lane placement is done by the memory.
- `req_ready` is 0 in ACCESS and RESP. There is no overlap and no queueing.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all `mem_*` = 0.
- Latency: request accepted on edge k; ACCESS during cycle k+1; `rsp_valid` high from cycle k+2. The minimum spacing between accepted requests is 3 cycles.
- A store asserts `mem_memwrite` for exactly one cycle, so memory commits exactly one write per store.
- `mem_memwrite` is gated by `!reset`. A reset asserted during ACCESS suppresses the write, and the next state is IDLE.
- Reset during RESP drops the response; `rsp_valid`=0 the next cycle.
- If `rsp_ready` is held low, the response is held indefinitely with all outputs stable.
- There is no combinational path from `req_*` to `mem_*` or to `rsp_*`.

## Configuration
- `MAU_MISALIGN_CHECK_EN` defined:
  - A word with `addr[1:0]`≠0, or a dword with `addr[2:0]`≠0, is an error.
  - The unit goes IDLE→RESP directly, skips ACCESS and issues no memory access.
  - Response is `rsp_err`=1, `rsp_rdata`=0.
- Undefined:
  - No check; `rsp_err` is tied to 0.
  - Low address bits pass through and the memory truncates them.

## Structure
- Package `mau_pkg`:
  - size encoding constants (SZ_B, SZ_W, SZ_D);
  - memwrite codes (MW_NONE/W/B/D);
  - FSM state enum.
- Sub-module `load_align`: combinational extract + sign/zero-extend, with inputs `readdata`, `addr[1:0]`, `size`, `unsigned`.

## Test plan
Preload memory address 0x10 with 64'h0123_4567_89AB_CDEF.
- LB 0x14 → `rsp_rdata`=64'hFFFF_FFFF_FFFF_FF89. LBU 0x14 → 64'h89.
- LW 0x10 → 64'h0000_0000_0123_4567. LW 0x14 → 64'hFFFF_FFFF_89AB_CDEF. LWU 0x14 → 64'h89AB_CDEF.
- SB 0x13, data 0xAA → `mem_memwrite`=2 for one cycle. A following LD 0x10 → 64'h0123_45AA_89AB_CDEF.
- SD 0x18 with `rsp_ready` low for 3 cycles → response stable, `req_ready`=0, one write only.
- With the macro: LW 0x12 → `rsp_err`=1, `rsp_rdata`=0, `mem_memwrite` never nonzero, response on cycle k+1.
- Reset asserted during ACCESS of SD 0x18 → no write (a later LD returns the old value), all outputs at reset values the next cycle.
